// File: rtl/word_scrambler.sv
// word_scrambler: loads a target word, LFSR-scrambles a working copy, then applies player swaps and flags the solve.
// Build option: define WORD_SCRAMBLER_MOVE_COUNT_EN to include the saturating swapCount_o counter.
module word_scrambler #(
    parameter int LETTER_W        = 5,
    parameter int MAX_LEN         = 8,
    parameter int SCRAMBLE_ROUNDS = 8
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic [MAX_LEN*LETTER_W-1:0] wordIn_i,
    input  logic [1:0]                  lettNum_i,
    input  logic                        scramPls_i,
    input  logic                        flipPls_i,
    input  logic [2:0]                  indIn1_i,
    input  logic [2:0]                  indIn2_i,
    input  logic                        abort_i,
    output logic [MAX_LEN*LETTER_W-1:0] lettersOut_o,
    output logic                        busy_o,
    output logic                        isCorrect_o,
    output logic                        idxErr_o,
    output logic [7:0]                  swapCount_o
);

    localparam int IDX_W   = 3;
    localparam int LEN_W   = IDX_W + 1;
    localparam int ROUND_W = 4;

    typedef logic [LETTER_W-1:0] letter_t;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SCRAMBLE,
        CHECK,
        PLAY,
        COMPARE
    } state_t;

    state_t             state_q, state_d;
    letter_t            work_q   [MAX_LEN];
    letter_t            work_d   [MAX_LEN];
    letter_t            target_q [MAX_LEN];
    letter_t            target_d [MAX_LEN];
    logic [LEN_W-1:0]   len_q, len_d;
    logic [1:0]         retry_q, retry_d;
    logic [ROUND_W-1:0] round_q, round_d;
    logic [7:0]         lfsr_q, lfsr_d;
    logic               busy_q, busy_d;
    logic               isCorrect_q, isCorrect_d;
    logic               idxErr_q, idxErr_d;

    logic [LEN_W-1:0]   lenIn;
    logic [IDX_W-1:0]   scrA, scrB, lastIdx;
    logic               flipBad;
    logic               wordsMatch;

    // An out-of-range index wraps once; since len >= 4 and idx <= 7 the result is always in range.
    function automatic logic [IDX_W-1:0] foldIdx(input logic [IDX_W-1:0] idx,
                                                 input logic [LEN_W-1:0] len);
        logic [LEN_W-1:0] wide;
        wide = {1'b0, idx};
        if (wide >= len) begin
            return IDX_W'(wide - len);
        end
        return idx;
    endfunction

    assign lenIn   = (lettNum_i == 2'd3) ? LEN_W'(6) : LEN_W'(lettNum_i) + LEN_W'(4);
    assign scrA    = foldIdx(lfsr_q[2:0], len_q);
    assign scrB    = foldIdx(lfsr_q[5:3], len_q);
    assign lastIdx = IDX_W'(len_q - LEN_W'(1));
    assign flipBad = ({1'b0, indIn1_i} >= len_q) || ({1'b0, indIn2_i} >= len_q) ||
                     (indIn1_i == indIn2_i);

    always_comb begin
        wordsMatch = 1'b1;
        for (int i = 0; i < MAX_LEN; i++) begin
            if ((LEN_W'(i) < len_q) && (work_q[i] != target_q[i])) begin
                wordsMatch = 1'b0;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        work_d      = work_q;
        target_d    = target_q;
        len_d       = len_q;
        retry_d     = retry_q;
        round_d     = round_q;
        isCorrect_d = 1'b0;
        idxErr_d    = 1'b0;
        busy_d      = 1'b0;
        lfsr_d      = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

        if ((state_q != IDLE) && abort_i) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (scramPls_i) begin
                        for (int i = 0; i < MAX_LEN; i++) begin
                            target_d[i] = (LEN_W'(i) < lenIn) ?
                                          wordIn_i[i*LETTER_W +: LETTER_W] : '0;
                            work_d[i]   = (LEN_W'(i) < lenIn) ?
                                          wordIn_i[i*LETTER_W +: LETTER_W] : '0;
                        end
                        len_d   = lenIn;
                        retry_d = '0;
                        round_d = '0;
                        state_d = LOAD;
                    end
                end
                LOAD: begin
                    state_d = SCRAMBLE;
                end
                SCRAMBLE: begin
                    work_d[scrA] = work_q[scrB];
                    work_d[scrB] = work_q[scrA];
                    round_d      = round_q + ROUND_W'(1);
                    if (round_q == ROUND_W'(SCRAMBLE_ROUNDS - 1)) begin
                        state_d = CHECK;
                    end
                end
                CHECK: begin
                    if (!wordsMatch) begin
                        state_d = PLAY;
                    end else if (retry_q != 2'd3) begin
                        retry_d = retry_q + 2'd1;
                        round_d = '0;
                        state_d = SCRAMBLE;
                    end else begin
                        // Give up on the LFSR and guarantee a visible change when letters differ.
                        work_d[0]       = work_q[lastIdx];
                        work_d[lastIdx] = work_q[0];
                        state_d         = PLAY;
                    end
                end
                PLAY: begin
                    if (flipPls_i) begin
                        if (flipBad) begin
                            idxErr_d = 1'b1;
                        end else begin
                            work_d[indIn1_i] = work_q[indIn2_i];
                            work_d[indIn2_i] = work_q[indIn1_i];
                            state_d          = COMPARE;
                        end
                    end
                end
                COMPARE: begin
                    if (wordsMatch) begin
                        isCorrect_d = 1'b1;
                        state_d     = IDLE;
                    end else begin
                        state_d = PLAY;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        busy_d = (state_d == LOAD) || (state_d == SCRAMBLE) ||
                 (state_d == CHECK) || (state_d == COMPARE);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q     <= IDLE;
            work_q      <= '{default: '0};
            target_q    <= '{default: '0};
            len_q       <= LEN_W'(4);
            retry_q     <= '0;
            round_q     <= '0;
            lfsr_q      <= 8'hA5;
            busy_q      <= 1'b0;
            isCorrect_q <= 1'b0;
            idxErr_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            work_q      <= work_d;
            target_q    <= target_d;
            len_q       <= len_d;
            retry_q     <= retry_d;
            round_q     <= round_d;
            lfsr_q      <= lfsr_d;
            busy_q      <= busy_d;
            isCorrect_q <= isCorrect_d;
            idxErr_q    <= idxErr_d;
        end
    end

`ifdef WORD_SCRAMBLER_MOVE_COUNT_EN
    logic       cntClear, cntInc;
    logic [7:0] swapCount_q, swapCount_d;

    assign cntClear = (state_q == IDLE) && scramPls_i;
    assign cntInc   = (state_q == PLAY) && !abort_i && flipPls_i && !flipBad;

    always_comb begin
        swapCount_d = swapCount_q;
        if (cntClear) begin
            swapCount_d = '0;
        end else if (cntInc && (swapCount_q != 8'hFF)) begin
            swapCount_d = swapCount_q + 8'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            swapCount_q <= '0;
        end else begin
            swapCount_q <= swapCount_d;
        end
    end

    assign swapCount_o = swapCount_q;
`else
    assign swapCount_o = 8'd0;
`endif

    for (genvar g = 0; g < MAX_LEN; g++) begin : gen_out
        assign lettersOut_o[g*LETTER_W +: LETTER_W] = work_q[g];
    end

    assign busy_o      = busy_q;
    assign isCorrect_o = isCorrect_q;
    assign idxErr_o    = idxErr_q;

endmodule

// File: tb/tb_word_scrambler.sv
// Bench for word_scrambler: random words and flips checked against a letter-level permutation model.
module tb_word_scrambler;
    localparam int LW = 5;
    localparam int ML = 8;
    localparam int WW = LW * ML;

    logic          clk      = 1'b0;
    logic          rst      = 1'b0;
    logic [WW-1:0] wordIn   = '0;
    logic [1:0]    lettNum  = '0;
    logic          scramPls = 1'b0;
    logic          flipPls  = 1'b0;
    logic          abort    = 1'b0;
    logic [2:0]    ind1     = '0;
    logic [2:0]    ind2     = '0;
    logic [WW-1:0] lettersOut;
    logic          busy, isCorrect, idxErr;
    logic [7:0]    swapCount;

    int checks = 0;
    int errors = 0;
    int tgt[ML];
    int cur[ML];
    int len = 4;
    int modelCount = 0;

    always #5 clk = ~clk;

    word_scrambler dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .wordIn_i     (wordIn),
        .lettNum_i    (lettNum),
        .scramPls_i   (scramPls),
        .flipPls_i    (flipPls),
        .indIn1_i     (ind1),
        .indIn2_i     (ind2),
        .abort_i      (abort),
        .lettersOut_o (lettersOut),
        .busy_o       (busy),
        .isCorrect_o  (isCorrect),
        .idxErr_o     (idxErr),
        .swapCount_o  (swapCount)
    );

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic int slotOf(input logic [WW-1:0] v, input int i);
        return int'(v[i*LW +: LW]);
    endfunction

    function automatic logic [WW-1:0] packTgt();
        logic [WW-1:0] v;
        for (int i = 0; i < ML; i++) v[i*LW +: LW] = (i < len) ? LW'(tgt[i]) : '0;
        return v;
    endfunction

    function automatic logic [WW-1:0] packCur();
        logic [WW-1:0] v;
        for (int i = 0; i < ML; i++) v[i*LW +: LW] = (i < len) ? LW'(cur[i]) : '0;
        return v;
    endfunction

    function automatic bit isPermOfTarget(input logic [WW-1:0] v);
        int h[32];
        for (int k = 0; k < 32; k++) h[k] = 0;
        for (int i = 0; i < len; i++) begin
            h[tgt[i]]++;
            h[slotOf(v, i)]--;
        end
        for (int i = len; i < ML; i++) if (slotOf(v, i) != 0) return 1'b0;
        for (int k = 0; k < 32; k++) if (h[k] != 0) return 1'b0;
        return 1'b1;
    endfunction

    function automatic bit curSolved();
        for (int i = 0; i < len; i++) if (cur[i] != tgt[i]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic bit swapSolves(input int a, input int b);
        int v;
        for (int i = 0; i < len; i++) begin
            v = (i == a) ? cur[b] : (i == b) ? cur[a] : cur[i];
            if (v != tgt[i]) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic logic [7:0] expCount();
`ifdef WORD_SCRAMBLER_MOVE_COUNT_EN
        return (modelCount > 255) ? 8'd255 : 8'(modelCount);
`else
        return 8'd0;
`endif
    endfunction

    task automatic modelSwap(input int a, input int b);
        int t;
        if (a < len && b < len && a != b) begin
            t = cur[a]; cur[a] = cur[b]; cur[b] = t;
            modelCount++;
        end
    endtask

    task automatic snapshot();
        for (int i = 0; i < ML; i++) cur[i] = (i < len) ? slotOf(lettersOut, i) : 0;
    endtask

    task automatic idle(input int k);
        repeat (k) @(negedge clk);
    endtask

    task automatic newWord(input int ln);
        int v;
        bit used[32];
        lettNum = 2'(ln);
        len = (ln == 3) ? 6 : ln + 4;
        for (int k = 0; k < 32; k++) used[k] = 1'b0;
        for (int i = 0; i < ML; i++) begin
            if (i < len) begin
                do v = int'($urandom_range(26, 1)); while (used[v]);
                used[v] = 1'b1;
                tgt[i] = v;
                wordIn[i*LW +: LW] = LW'(v);
            end else begin
                tgt[i] = 0;
                wordIn[i*LW +: LW] = LW'($urandom_range(31, 1));
            end
        end
    endtask

    task automatic setWord(input int w[4], input int ln);
        lettNum = 2'(ln);
        len = 4;
        for (int i = 0; i < ML; i++) begin
            tgt[i] = (i < 4) ? w[i] : 0;
            wordIn[i*LW +: LW] = (i < 4) ? LW'(w[i]) : LW'($urandom_range(31, 1));
        end
    endtask

    task automatic pickInvalid(output int a, output int b);
        case ($urandom_range(2, 0))
            0: begin a = int'($urandom_range(7, len)); b = int'($urandom_range(7, 0)); end
            1: begin a = int'($urandom_range(len - 1, 0)); b = int'($urandom_range(7, len)); end
            default: begin a = int'($urandom_range(len - 1, 0)); b = a; end
        endcase
    endtask

    task automatic findPair(output int a, output int b);
        a = 0; b = 1;
        for (int i = 0; i < len; i++)
            for (int j = i + 1; j < len; j++)
                if (!swapSolves(i, j)) begin a = i; b = j; return; end
    endtask

    // Pulse scramPls and count the busy cycles that follow; leaves the bench just after a negedge.
    task automatic scramble(output int n);
        scramPls = 1'b1;
        @(negedge clk);
        scramPls = 1'b0;
        modelCount = 0;
        n = 0;
        while (busy === 1'b1 && n < 60) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic flip(input int a, input int b, output logic [WW-1:0] l1, output logic e1,
                        output logic b1, output logic c1, output logic e2, output logic c2);
        flipPls = 1'b1; ind1 = 3'(a); ind2 = 3'(b);
        @(negedge clk);
        flipPls = 1'b0;
        l1 = lettersOut; e1 = idxErr; b1 = busy; c1 = isCorrect;
        @(negedge clk);
        e2 = idxErr; c2 = isCorrect;
    endtask

    task automatic test_reset();
        rst = 1'b0; scramPls = 1'b1; flipPls = 1'b1; ind1 = 3'd0; ind2 = 3'd1;
        repeat (2) @(negedge clk);
        checks++;
        if (lettersOut !== '0) begin errors++; $display("[TB] FAIL reset_letters: got %h expected 0", lettersOut); end
        checks++;
        if ({busy, isCorrect, idxErr} !== 3'b000) begin errors++; $display("[TB] FAIL reset_flags: got %b expected 000", {busy, isCorrect, idxErr}); end
        checks++;
        if (swapCount !== 8'd0) begin errors++; $display("[TB] FAIL reset_count: got %0d expected 0", swapCount); end
        scramPls = 1'b0; flipPls = 1'b0; rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({busy, isCorrect, idxErr} !== 3'b000 || lettersOut !== '0) begin
            errors++; $display("[TB] FAIL reset_release: got %b/%h expected 000/0", {busy, isCorrect, idxErr}, lettersOut);
        end
        modelCount = 0;
    endtask

    task automatic test_solve(input int ln, input bit noise, input bit useCode);
        int n, j, a, b, corr;
        int code[4];
        logic [WW-1:0] l1;
        logic e1, b1, c1, e2, c2;
        code = '{3, 15, 4, 5};
        if (useCode) setWord(code, 0); else newWord(ln);
        idle(int'($urandom_range(5, 0)));
        scramble(n);
        checks++;
        if (n != 10 && n != 19 && n != 28 && n != 37) begin errors++; $display("[TB] FAIL solve_busy_len: got %0d expected 10+9k", n); end
        checks++;
        if (isPermOfTarget(lettersOut) !== 1'b1) begin errors++; $display("[TB] FAIL solve_perm: got %h expected permutation of %h", lettersOut, packTgt()); end
        checks++;
        if (lettersOut === packTgt()) begin errors++; $display("[TB] FAIL solve_differs: got %h expected not %h", lettersOut, packTgt()); end
        checks++;
        if (swapCount !== expCount()) begin errors++; $display("[TB] FAIL solve_count_clear: got %0d expected %0d", swapCount, expCount()); end
        snapshot();
        corr = 0;
        for (int i = 0; i < len; i++) begin
            if (cur[i] != tgt[i]) begin
                if (noise && $urandom_range(1, 0) == 1) begin
                    pickInvalid(a, b);
                    flip(a, b, l1, e1, b1, c1, e2, c2);
                    corr += int'(c1) + int'(c2);
                    checks++;
                    if ({e1, e2} !== 2'b10) begin errors++; $display("[TB] FAIL solve_idxerr: got %b expected 10 (%0d,%0d)", {e1, e2}, a, b); end
                    checks++;
                    if (l1 !== packCur()) begin errors++; $display("[TB] FAIL solve_reject_letters: got %h expected %h", l1, packCur()); end
                end
                j = i + 1;
                while (j < len && cur[j] != tgt[i]) j++;
                if (j >= len) j = len - 1;
                modelSwap(i, j);
                flip(i, j, l1, e1, b1, c1, e2, c2);
                corr += int'(c1) + int'(c2);
                checks++;
                if (l1 !== packCur()) begin errors++; $display("[TB] FAIL solve_swap_letters: got %h expected %h", l1, packCur()); end
                checks++;
                if ({e1, b1, c1} !== 3'b010) begin errors++; $display("[TB] FAIL solve_flip_flags: got %b expected 010", {e1, b1, c1}); end
                checks++;
                if (c2 !== curSolved()) begin errors++; $display("[TB] FAIL solve_iscorrect: got %b expected %b", c2, curSolved()); end
                checks++;
                if (swapCount !== expCount()) begin errors++; $display("[TB] FAIL solve_count: got %0d expected %0d", swapCount, expCount()); end
            end
        end
        @(negedge clk);
        checks++;
        if (isCorrect !== 1'b0 || busy !== 1'b0) begin errors++; $display("[TB] FAIL solve_after: got %b%b expected 00", isCorrect, busy); end
        checks++;
        if (corr != 1) begin errors++; $display("[TB] FAIL solve_pulses: got %0d expected 1", corr); end
    endtask

    task automatic test_reject();
        int n, a, b, c, d;
        logic [WW-1:0] l1;
        logic e1, b1, c1, e2, c2;
        newWord(1);
        scramble(n);
        checks++;
        if (isPermOfTarget(lettersOut) !== 1'b1 || n < 10) begin errors++; $display("[TB] FAIL reject_scramble: got %h/%0d expected permutation", lettersOut, n); end
        snapshot();
        flip(5, 1, l1, e1, b1, c1, e2, c2);
        checks++;
        if ({e1, e2, c1, c2} !== 4'b1000) begin errors++; $display("[TB] FAIL reject_idx5: got %b expected 1000", {e1, e2, c1, c2}); end
        checks++;
        if (l1 !== packCur() || swapCount !== expCount()) begin errors++; $display("[TB] FAIL reject_idx5_state: got %h/%0d expected %h/%0d", l1, swapCount, packCur(), expCount()); end
        flip(2, 2, l1, e1, b1, c1, e2, c2);
        checks++;
        if ({e1, e2} !== 2'b10) begin errors++; $display("[TB] FAIL reject_equal: got %b expected 10", {e1, e2}); end
        checks++;
        if (l1 !== packCur() || swapCount !== expCount()) begin errors++; $display("[TB] FAIL reject_equal_state: got %h/%0d expected %h/%0d", l1, swapCount, packCur(), expCount()); end
        findPair(a, b);
        c = (a + 1) % len; d = (a + 2) % len;
        modelSwap(a, b);
        flipPls = 1'b1; ind1 = 3'(a); ind2 = 3'(b);
        @(negedge clk);
        ind1 = 3'(c); ind2 = 3'(d);
        checks++;
        if (lettersOut !== packCur() || busy !== 1'b1) begin errors++; $display("[TB] FAIL reject_valid: got %h/%b expected %h/1", lettersOut, busy, packCur()); end
        @(negedge clk);
        flipPls = 1'b0;
        checks++;
        if ({busy, isCorrect, idxErr} !== 3'b000) begin errors++; $display("[TB] FAIL compare_drop_flags: got %b expected 000", {busy, isCorrect, idxErr}); end
        @(negedge clk);
        checks++;
        if (lettersOut !== packCur() || swapCount !== expCount()) begin errors++; $display("[TB] FAIL compare_drop: got %h/%0d expected %h/%0d", lettersOut, swapCount, packCur(), expCount()); end
    endtask

    task automatic test_abort_play();
        logic [WW-1:0] l1;
        logic e1, b1, c1, e2, c2;
        abort = 1'b1; flipPls = 1'b1; ind1 = 3'd0; ind2 = 3'd1;
        @(negedge clk);
        abort = 1'b0; flipPls = 1'b0;
        checks++;
        if (lettersOut !== packCur()) begin errors++; $display("[TB] FAIL abort_play_letters: got %h expected %h", lettersOut, packCur()); end
        checks++;
        if ({busy, isCorrect, idxErr} !== 3'b000) begin errors++; $display("[TB] FAIL abort_play_flags: got %b expected 000", {busy, isCorrect, idxErr}); end
        flip(0, 1, l1, e1, b1, c1, e2, c2);
        checks++;
        if (l1 !== packCur() || {e1, b1, c1, e2, c2} !== 5'b00000) begin
            errors++; $display("[TB] FAIL idle_flip_drop: got %h/%b expected %h/00000", l1, {e1, b1, c1, e2, c2}, packCur());
        end
        checks++;
        if (swapCount !== expCount()) begin errors++; $display("[TB] FAIL abort_play_count: got %0d expected %0d", swapCount, expCount()); end
    endtask

    task automatic test_degenerate();
        int n;
        int aaaa[4];
        logic [WW-1:0] l1;
        logic e1, b1, c1, e2, c2;
        aaaa = '{1, 1, 1, 1};
        setWord(aaaa, 0);
        scramble(n);
        checks++;
        if (n != 37) begin errors++; $display("[TB] FAIL degen_busy_len: got %0d expected 37", n); end
        checks++;
        if (lettersOut !== packTgt()) begin errors++; $display("[TB] FAIL degen_letters: got %h expected %h", lettersOut, packTgt()); end
        snapshot();
        modelSwap(1, 2);
        flip(1, 2, l1, e1, b1, c1, e2, c2);
        checks++;
        if ({e1, b1, c1, c2} !== 4'b0101) begin errors++; $display("[TB] FAIL degen_first_flip: got %b expected 0101", {e1, b1, c1, c2}); end
        checks++;
        if (swapCount !== expCount()) begin errors++; $display("[TB] FAIL degen_count: got %0d expected %0d", swapCount, expCount()); end
    endtask

    task automatic test_abort_scramble();
        int k, hits;
        newWord(int'($urandom_range(3, 0)));
        scramPls = 1'b1;
        @(negedge clk);
        scramPls = 1'b0;
        k = int'($urandom_range(7, 1));
        idle(k);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("[TB] FAIL abort_scr_busy: got %b expected 1", busy); end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checks++;
        if ({busy, isCorrect} !== 2'b00) begin errors++; $display("[TB] FAIL abort_scr_flags: got %b expected 00", {busy, isCorrect}); end
        checks++;
        if (isPermOfTarget(lettersOut) !== 1'b1) begin errors++; $display("[TB] FAIL abort_scr_perm: got %h expected permutation of %h", lettersOut, packTgt()); end
        hits = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (busy !== 1'b0 || isCorrect !== 1'b0) hits++;
        end
        checks++;
        if (hits != 0) begin errors++; $display("[TB] FAIL abort_scr_stays_idle: got %0d active cycles expected 0", hits); end
    endtask

    task automatic test_reset_compare();
        int n, a, b;
        newWord(2);
        scramble(n);
        snapshot();
        findPair(a, b);
        flipPls = 1'b1; ind1 = 3'(a); ind2 = 3'(b);
        @(negedge clk);
        flipPls = 1'b0;
        checks++;
        if (busy !== 1'b1) begin errors++; $display("[TB] FAIL rstcmp_in_compare: got %b expected 1", busy); end
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        modelCount = 0;
        checks++;
        if (lettersOut !== '0 || swapCount !== 8'd0) begin errors++; $display("[TB] FAIL rstcmp_data: got %h/%0d expected 0/0", lettersOut, swapCount); end
        checks++;
        if ({busy, isCorrect, idxErr} !== 3'b000) begin errors++; $display("[TB] FAIL rstcmp_flags: got %b expected 000", {busy, isCorrect, idxErr}); end
        @(negedge clk);
        checks++;
        if ({busy, isCorrect} !== 2'b00) begin errors++; $display("[TB] FAIL rstcmp_idle: got %b expected 00", {busy, isCorrect}); end
    endtask

    task automatic test_saturate();
        int n, a, b;
        logic [WW-1:0] l1;
        logic e1, b1, c1, e2, c2;
        newWord(0);
        scramble(n);
        snapshot();
        findPair(a, b);
        for (int k = 0; k < 260; k++) begin
            modelSwap(a, b);
            flip(a, b, l1, e1, b1, c1, e2, c2);
        end
        checks++;
        if (swapCount !== expCount()) begin errors++; $display("[TB] FAIL saturate_count: got %0d expected %0d", swapCount, expCount()); end
        checks++;
        if (lettersOut !== packCur()) begin errors++; $display("[TB] FAIL saturate_letters: got %h expected %h", lettersOut, packCur()); end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
    endtask

    initial begin
        test_reset();
        test_solve(0, 1'b0, 1'b1);
        test_reject();
        test_abort_play();
        test_degenerate();
        test_abort_scramble();
        test_reset_compare();
        test_saturate();
        for (int g = 0; g < 8; g++) test_solve(int'($urandom_range(3, 0)), 1'b1, 1'b0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
